// File: rtl/fads_pkg.sv
// Shared types and defaults for the FADS sort scheduler.
package fads_pkg;

    localparam int unsigned FADS_TW                 = 32;
    localparam int unsigned FADS_QAW                = 3;
    localparam int unsigned FADS_SORT_DEFAULT_PULSE = 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_FIRE = 2'd2,
        ST_GAP  = 2'd3
    } sched_state_e;

endpackage

// File: rtl/fads_ts_fifo.sv
// Timestamp FIFO, 2^QAW deep, show-ahead head, synchronous clear.
// A push into a full FIFO is ignored even if a pop happens in the same cycle.
module fads_ts_fifo
    import fads_pkg::*;
#(
    parameter int unsigned TW  = FADS_TW,
    parameter int unsigned QAW = FADS_QAW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          push,
    input  logic [TW-1:0] push_data,
    input  logic          pop,
    output logic [TW-1:0] head_c,
    output logic [QAW:0]  count,
    output logic          full,
    output logic          empty
);

    localparam int unsigned DEPTH = 1 << QAW;

    logic [TW-1:0]  mem [DEPTH];
    logic [QAW-1:0] wr_ptr;
    logic [QAW-1:0] rd_ptr;
    logic           do_push;
    logic           do_pop;
    logic [QAW:0]   count_d;

    // Qualify push/pop against the state before this edge.
    always_comb begin
        do_push = push & ~full & ~clear;
        do_pop  = pop & ~empty & ~clear;
        count_d = count;
        if (clear) begin
            count_d = '0;
        end else if (do_push && !do_pop) begin
            count_d = count + (QAW+1)'(1);
        end else if (do_pop && !do_push) begin
            count_d = count - (QAW+1)'(1);
        end
    end

    // Storage array, no reset needed.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers, occupancy and registered full/empty flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (clear) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (do_push) wr_ptr <= wr_ptr + QAW'(1);
                if (do_pop)  rd_ptr <= rd_ptr + QAW'(1);
            end
            count <= count_d;
            full  <= (count_d == (QAW+1)'(DEPTH));
            empty <= (count_d == '0);
        end
    end

    assign head_c = mem[rd_ptr];

endmodule

// File: rtl/red_pitaya_fads_sort_sched.sv
// FADS sort scheduler: queues due-times of positive droplets and issues one
// sort pulse per droplet in arrival order with a one-cycle low gap.
// Optional statistics counters are built when FADS_SORT_STATS_EN is defined.
module red_pitaya_fads_sort_sched
    import fads_pkg::*;
#(
    parameter int unsigned TW  = FADS_TW,
    parameter int unsigned QAW = FADS_QAW
) (
    input  logic          adc_clk_i,
    input  logic          adc_rstn_i,
    input  logic          det_valid_i,
    input  logic          det_positive_i,
    input  logic          cfg_enable_i,
    input  logic [TW-1:0] cfg_delay_i,
    input  logic [TW-1:0] cfg_pulse_len_i,
    input  logic          flush_i,
    output logic          sort_trig_o,
    output logic          busy_o,
    output logic [QAW:0]  pending_o,
    output logic [TW-1:0] sorted_cnt_o,
    output logic [TW-1:0] dropped_cnt_o
);

    sched_state_e  state_q, state_d;
    logic [TW-1:0] now_q;
    logic [TW-1:0] len_q, len_d;
    logic          trig_d;
    logic          push_req_c;
    logic          pop_c;
    logic [TW-1:0] head_c;
    logic [TW-1:0] diff_c;
    logic          head_due_c;
    logic          fifo_full;
    logic          fifo_empty;

    assign push_req_c = det_valid_i & det_positive_i & cfg_enable_i & ~flush_i;
    assign diff_c     = now_q - head_c;
    assign head_due_c = ~diff_c[TW-1];

    fads_ts_fifo #(
        .TW  (TW),
        .QAW (QAW)
    ) u_fifo (
        .clk       (adc_clk_i),
        .rst_n     (adc_rstn_i),
        .clear     (flush_i),
        .push      (push_req_c & ~fifo_full),
        .push_data (now_q + cfg_delay_i),
        .pop       (pop_c),
        .head_c    (head_c),
        .count     (pending_o),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Next-state logic. Any non-FIRE state may start a due pulse directly,
    // which gives the max(D,1) latency and the single-cycle inter-pulse gap.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        trig_d  = sort_trig_o;
        pop_c   = 1'b0;
        if (flush_i) begin
            state_d = ST_IDLE;
            trig_d  = 1'b0;
        end else begin
            case (state_q)
                ST_FIRE: begin
                    if (len_q <= TW'(1)) begin
                        trig_d  = 1'b0;
                        state_d = ST_GAP;
                    end else begin
                        len_d = len_q - TW'(1);
                    end
                end
                default: begin
                    if (!fifo_empty && head_due_c) begin
                        pop_c   = 1'b1;
                        trig_d  = 1'b1;
                        len_d   = (cfg_pulse_len_i == '0) ? TW'(FADS_SORT_DEFAULT_PULSE)
                                                          : cfg_pulse_len_i;
                        state_d = ST_FIRE;
                    end else if (!fifo_empty) begin
                        state_d = ST_WAIT;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            endcase
        end
    end

    // State, pulse length, trigger and busy registers; free-running time base.
    always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
        if (!adc_rstn_i) begin
            state_q     <= ST_IDLE;
            len_q       <= '0;
            sort_trig_o <= 1'b0;
            busy_o      <= 1'b0;
            now_q       <= '0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            sort_trig_o <= trig_d;
            busy_o      <= (state_d != ST_IDLE);
            now_q       <= now_q + TW'(1);
        end
    end

`ifdef FADS_SORT_STATS_EN
    logic [TW-1:0] sorted_q;
    logic [TW-1:0] dropped_q;

    // Saturating statistics counters.
    always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
        if (!adc_rstn_i) begin
            sorted_q  <= '0;
            dropped_q <= '0;
        end else begin
            if (pop_c && sorted_q != '1) begin
                sorted_q <= sorted_q + TW'(1);
            end
            if (push_req_c && fifo_full && dropped_q != '1) begin
                dropped_q <= dropped_q + TW'(1);
            end
        end
    end

    assign sorted_cnt_o  = sorted_q;
    assign dropped_cnt_o = dropped_q;
`else
    assign sorted_cnt_o  = '0;
    assign dropped_cnt_o = '0;
`endif

endmodule

// File: tb/tb_red_pitaya_fads_sort_sched.sv
// Directed bench for red_pitaya_fads_sort_sched (32-bit main instance plus an
// 8-bit instance used to exercise time-base wrap).
module tb_red_pitaya_fads_sort_sched;

`ifdef FADS_SORT_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        det_valid, det_positive, cfg_enable, flush;
    logic [31:0] cfg_delay, cfg_pulse_len;
    logic        sort_trig, busy;
    logic [3:0]  pending;
    logic [31:0] sorted_cnt, dropped_cnt;

    logic        s_valid, s_positive, s_enable, s_flush;
    logic [7:0]  s_delay, s_len;
    logic        s_trig, s_busy;
    logic [3:0]  s_pending;
    logic [7:0]  s_sorted, s_dropped;
    logic [7:0]  s_now;

    int n_assert = 0;
    int n_fail   = 0;
    int rises    = 0;
    int rises_ref;
    logic trig_prev = 1'b0;

    always #5 clk = ~clk;

    red_pitaya_fads_sort_sched dut (
        .adc_clk_i       (clk),
        .adc_rstn_i      (rst_n),
        .det_valid_i     (det_valid),
        .det_positive_i  (det_positive),
        .cfg_enable_i    (cfg_enable),
        .cfg_delay_i     (cfg_delay),
        .cfg_pulse_len_i (cfg_pulse_len),
        .flush_i         (flush),
        .sort_trig_o     (sort_trig),
        .busy_o          (busy),
        .pending_o       (pending),
        .sorted_cnt_o    (sorted_cnt),
        .dropped_cnt_o   (dropped_cnt)
    );

    red_pitaya_fads_sort_sched #(.TW(8), .QAW(3)) dut8 (
        .adc_clk_i       (clk),
        .adc_rstn_i      (rst_n),
        .det_valid_i     (s_valid),
        .det_positive_i  (s_positive),
        .cfg_enable_i    (s_enable),
        .cfg_delay_i     (s_delay),
        .cfg_pulse_len_i (s_len),
        .flush_i         (s_flush),
        .sort_trig_o     (s_trig),
        .busy_o          (s_busy),
        .pending_o       (s_pending),
        .sorted_cnt_o    (s_sorted),
        .dropped_cnt_o   (s_dropped)
    );

    // Reference time base for the 8-bit instance.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) s_now <= 8'd0;
        else        s_now <= s_now + 8'd1;
    end

    // Count rising edges of the main trigger, sampled just after each edge.
    always @(posedge clk) begin
        #1;
        if (sort_trig && !trig_prev) rises++;
        trig_prev = sort_trig;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] st(input int v);
        return STATS ? 64'(v) : 64'd0;
    endfunction

    initial begin
        rst_n = 1'b0;
        det_valid = 1'b0; det_positive = 1'b0; cfg_enable = 1'b1; flush = 1'b0;
        cfg_delay = 32'd0; cfg_pulse_len = 32'd0;
        s_valid = 1'b0; s_positive = 1'b1; s_enable = 1'b1; s_flush = 1'b0;
        s_delay = 8'd0; s_len = 8'd0;
        tick(3);
        chk("rst_trig",    64'(sort_trig),   64'd0);
        chk("rst_busy",    64'(busy),        64'd0);
        chk("rst_pending", 64'(pending),     64'd0);
        chk("rst_sorted",  64'(sorted_cnt),  64'd0);
        chk("rst_dropped", 64'(dropped_cnt), 64'd0);
        rst_n = 1'b1;
        tick(2);

        // Single event, D=100, L=20.
        cfg_delay = 32'd100; cfg_pulse_len = 32'd20;
        det_valid = 1'b1; det_positive = 1'b1;
        tick(1);
        det_valid = 1'b0;
        chk("t1_pending_push", 64'(pending), 64'd1);
        chk("t1_busy_idle",    64'(busy),    64'd0);
        tick(99);
        chk("t1_trig_before",  64'(sort_trig), 64'd0);
        tick(1);
        chk("t1_trig_rise",    64'(sort_trig), 64'd1);
        chk("t1_pending_pop",  64'(pending),   64'd0);
        chk("t1_sorted",       64'(sorted_cnt), st(1));
        tick(19);
        chk("t1_trig_last",    64'(sort_trig), 64'd1);
        tick(1);
        chk("t1_trig_fall",    64'(sort_trig), 64'd0);
        chk("t1_busy_gap",     64'(busy),      64'd1);
        tick(1);
        chk("t1_busy_idle_end", 64'(busy),     64'd0);
        tick(3);

        // Three events 5 cycles apart, D=50, L=10.
        cfg_delay = 32'd50; cfg_pulse_len = 32'd10;
        det_valid = 1'b1; tick(1); det_valid = 1'b0;
        tick(4);
        det_valid = 1'b1; tick(1); det_valid = 1'b0;
        tick(4);
        det_valid = 1'b1; tick(1); det_valid = 1'b0;
        chk("t2_pending3", 64'(pending), 64'd3);
        tick(39);
        chk("t2_p1_before", 64'(sort_trig), 64'd0);
        tick(1);
        chk("t2_p1_rise",   64'(sort_trig), 64'd1);
        chk("t2_pending2",  64'(pending),   64'd2);
        tick(9);
        chk("t2_p1_last",   64'(sort_trig), 64'd1);
        tick(1);
        chk("t2_gap1",      64'(sort_trig), 64'd0);
        tick(1);
        chk("t2_p2_rise",   64'(sort_trig), 64'd1);
        chk("t2_pending1",  64'(pending),   64'd1);
        tick(10);
        chk("t2_gap2",      64'(sort_trig), 64'd0);
        tick(1);
        chk("t2_p3_rise",   64'(sort_trig), 64'd1);
        chk("t2_pending0",  64'(pending),   64'd0);
        tick(10);
        chk("t2_p3_fall",   64'(sort_trig), 64'd0);
        tick(1);
        chk("t2_idle",      64'(busy),      64'd0);
        chk("t2_sorted",    64'(sorted_cnt), st(4));

        // Disabled and negative events are ignored.
        cfg_enable = 1'b0; det_valid = 1'b1; det_positive = 1'b1; tick(1);
        cfg_enable = 1'b1; det_positive = 1'b0; tick(1);
        det_valid = 1'b0; det_positive = 1'b1;
        tick(1);
        chk("t_ign_pending", 64'(pending),     64'd0);
        chk("t_ign_busy",    64'(busy),        64'd0);
        chk("t_ign_dropped", 64'(dropped_cnt), 64'd0);

        // Ten consecutive events into a depth-8 queue, D=1000, L=2.
        cfg_delay = 32'd1000; cfg_pulse_len = 32'd2;
        rises_ref = rises;
        det_valid = 1'b1; tick(10); det_valid = 1'b0;
        chk("t3_pending_full", 64'(pending),     64'd8);
        chk("t3_dropped",      64'(dropped_cnt), st(2));
        tick(1030);
        chk("t3_pulses",       64'(rises - rises_ref), 64'd8);
        chk("t3_pending0",     64'(pending),     64'd0);
        chk("t3_idle",         64'(busy),        64'd0);
        chk("t3_sorted",       64'(sorted_cnt),  st(12));

        // Flush during cycle 5 of a 20-cycle pulse with 3 entries queued.
        cfg_delay = 32'd10; cfg_pulse_len = 32'd20;
        det_valid = 1'b1; tick(4); det_valid = 1'b0;
        tick(7);
        chk("t4_trig_on",  64'(sort_trig), 64'd1);
        chk("t4_pending3", 64'(pending),   64'd3);
        tick(4);
        rises_ref = rises;
        flush = 1'b1; det_valid = 1'b1;
        tick(1);
        flush = 1'b0; det_valid = 1'b0;
        chk("t4_trig_off", 64'(sort_trig), 64'd0);
        chk("t4_pending0", 64'(pending),   64'd0);
        chk("t4_idle",     64'(busy),      64'd0);
        tick(60);
        chk("t4_no_pulses", 64'(rises - rises_ref), 64'd0);
        chk("t4_sorted",   64'(sorted_cnt),  st(13));
        chk("t4_dropped",  64'(dropped_cnt), st(2));

        // Time-base wrap on the 8-bit instance: push at now=246, D=30, L=5.
        for (int i = 0; i < 300 && s_now != 8'd246; i++) tick(1);
        s_delay = 8'd30; s_len = 8'd5;
        s_valid = 1'b1; tick(1); s_valid = 1'b0;
        chk("t5_pending", 64'(s_pending), 64'd1);
        tick(29);
        chk("t5_before",  64'(s_trig), 64'd0);
        tick(1);
        chk("t5_rise",    64'(s_trig), 64'd1);
        tick(5);
        chk("t5_fall",    64'(s_trig), 64'd0);

        // D=0, L=0: one-cycle pulse on the edge after sampling.
        cfg_delay = 32'd0; cfg_pulse_len = 32'd0;
        det_valid = 1'b1; tick(1); det_valid = 1'b0;
        chk("t6_before", 64'(sort_trig), 64'd0);
        tick(1);
        chk("t6_rise",   64'(sort_trig), 64'd1);
        tick(1);
        chk("t6_fall",   64'(sort_trig), 64'd0);
        chk("t6_sorted", 64'(sorted_cnt), st(14));
        tick(3);

        // Reset asserted mid-pulse clears outputs without a clock edge.
        cfg_pulse_len = 32'd4;
        det_valid = 1'b1; tick(1); det_valid = 1'b0;
        tick(1);
        chk("t7_rise", 64'(sort_trig), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t7_rst_trig",    64'(sort_trig),   64'd0);
        chk("t7_rst_busy",    64'(busy),        64'd0);
        chk("t7_rst_pending", 64'(pending),     64'd0);
        chk("t7_rst_sorted",  64'(sorted_cnt),  64'd0);
        chk("t7_rst_dropped", 64'(dropped_cnt), 64'd0);
        tick(2);
        rst_n = 1'b1;
        tick(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/red_pitaya_fads_sort_sched.md
# red_pitaya_fads_sort_sched

Scheduler between the FADS droplet classifier and the ASG trigger input. It queues one timestamp per positive droplet and holds it for the flight time from detection point to sorting junction. It then issues one sort pulse of programmable width per droplet, in arrival order, with a guaranteed low gap between pulses. Config comes from the FADS register block; statistics are read back through it.

## Interface
- TW, 32: width of timestamp, delay, pulse-length and counter values
- QAW, 3: queue address width; depth = 2^QAW entries
- adc_clk_i  in  1  ADC clock, single clock domain
- adc_rstn_i  in  1  reset, asynchronous, active-low
- det_valid_i  in  1  one-cycle strobe: droplet classification complete
- det_positive_i  in  1  qualifies det_valid_i: droplet is to be sorted
- cfg_enable_i  in  1  accept new positive events
- cfg_delay_i  in  TW  detection-to-pulse delay in cycles, < 2^(TW-1)
- cfg_pulse_len_i  in  TW  sort pulse width in cycles; 0 treated as 1
- flush_i  in  1  synchronous clear of queue and any active pulse
- sort_trig_o  out  1  sort trigger to ASG, registered
- busy_o  out  1  state != IDLE, registered
- pending_o  out  QAW+1  queue occupancy
- sorted_cnt_o  out  TW  pulses started (stats)
- dropped_cnt_o  out  TW  positive events lost to full queue (stats)

## Operation
- now: free-running TW-bit counter, +1 per cycle, wraps modulo 2^TW.
- Push: on det_valid_i & det_positive_i & cfg_enable_i, write due = now + cfg_delay_i (mod 2^TW).
- If the queue is full, the event is dropped and dropped_cnt_o is incremented. Full is evaluated before any same-cycle pop.
- With cfg_enable_i low, events are ignored and not counted. Entries already queued still fire.
- Due test is wrap-safe: head is due when $signed(now - head_due) >= 0.
- FSM states:
  - IDLE: queue empty, trigger low. Go to WAIT when the queue is non-empty.
  - WAIT: when the head is due, pop it, load the length counter with max(cfg_pulse_len_i,1), set sort_trig_o, increment sorted_cnt_o, and go to FIRE.
  - FIRE: count down. At 1, clear the trigger and go to GAP.
  - GAP: exactly one low cycle. Go to WAIT if the queue is non-empty, else IDLE.
- Late entries (due passed during FIRE/GAP) fire on the first WAIT cycle. They are never skipped.
- cfg_pulse_len_i is sampled only at pulse start. cfg_delay_i is sampled only at push.
- A push and a pop in the same cycle are both performed; occupancy is unchanged.
- flush_i (highest priority):
  - queue emptied, FSM to IDLE, trigger low on the next edge.
  - A push in the same cycle is discarded and counters are untouched.
- Counters saturate at 2^TW-1.
- Reset: now, queue pointers, counters and length counter = 0. FSM IDLE; sort_trig_o, busy_o = 0; pending_o = 0.

## Timing
- Event sampled at edge e0 with delay D into an empty, idle scheduler: sort_trig_o rises after edge e(max(D,1)).
- Trigger stays high exactly L = max(cfg_pulse_len_i,1) cycles.
- Back-to-back entries: the next rise is no earlier than L+1 cycles after the previous rise.
- pending_o updates one edge after push/pop. busy_o is high from the edge entering WAIT to the edge entering IDLE.
- Reset assertion mid-pulse drops sort_trig_o asynchronously.

## Configuration
- FADS_SORT_STATS_EN:
  - Defined: sorted_cnt_o and dropped_cnt_o are implemented as above.
  - Undefined: both counters are removed and tied to 0. Scheduling is identical.

## Structure
- Shared package fads_pkg:
  - FSM state enum (IDLE, WAIT, FIRE, GAP)
  - default TW and QAW
  - FADS_SORT_DEFAULT_PULSE constant (1)
- Sub-module fads_ts_fifo:
  - synchronous TW-wide FIFO, 2^QAW deep, show-ahead head output
  - count, full and empty outputs
  - synchronous clear input
  - same-cycle push and pop supported
- Scheduler FSM, now counter and stats counters live in red_pitaya_fads_sort_sched.

## Test plan
- Single event, D=100, L=20: trigger rises 100 cycles after the sampling edge, high 20 cycles. sorted=1, pending returns 0.
- Three events 5 cycles apart, D=50, L=10: three pulses, each 10 high with a 1-cycle gap. The 2nd and 3rd start late, back-to-back; none lost.
- Depth 8, 10 events in 10 consecutive cycles, D=1000: pending_o=8, dropped=2, then exactly 8 pulses.
- now preloaded near 2^32-10, D=30: trigger rises exactly 30 cycles later across the wrap.
- flush_i during cycle 5 of a 20-cycle pulse with 3 entries queued: trigger low on the next edge, pending 0, IDLE, no further pulses.
- cfg_pulse_len_i=0 and D=0: 1-cycle pulse rising on the edge after the sampling edge. Reset asserted mid-pulse clears all outputs immediately.
